// File: rtl/queue_arb_pkg.sv
// Shared types and default sizing for the queue enqueue arbiter.
package queue_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int unsigned default_num_reqs   = 4;
  localparam int unsigned default_data_width = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above prio_ptr, wrapping to 0.
module rr_pick #(
  parameter int num_reqs = 4,
  parameter int id_width = $clog2(num_reqs)
) (
  input  logic [num_reqs-1:0] req,
  input  logic [id_width-1:0] prio_ptr,
  output logic [id_width-1:0] idx,
  output logic                any
);

  int p;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    p   = 0;
    for (int k = num_reqs - 1; k >= 0; k--) begin
      p = int'(prio_ptr) + k;
      if (p >= num_reqs) p = p - num_reqs;
      if (req[p]) begin
        idx = id_width'(p);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/queue_enq_arbiter.sv
// N-to-1 enqueue arbiter with burst locking and round-robin priority between bursts.
//   state  | meaning
//   IDLE   | no owner; round-robin pick from prio_ptr among valid requesters
//   LOCKED | owner holds the queue until it transfers its last beat
module queue_enq_arbiter
  import queue_arb_pkg::*;
#(
  parameter int num_reqs   = default_num_reqs,
  parameter int data_width = default_data_width,
  parameter int id_width   = $clog2(num_reqs)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [num_reqs-1:0]                  in_val,
  input  logic [num_reqs-1:0]                  in_last,
  input  logic [num_reqs-1:0][data_width-1:0]  in_msg,
  output logic [num_reqs-1:0]                  in_rdy,
  output logic                                 out_en,
  input  logic                                 out_rdy,
  output logic [data_width-1:0]                out_msg,
  output logic [id_width-1:0]                  grant_id,
  output logic                                 locked
);

  arb_state_t          state, state_nxt;
  logic [id_width-1:0] owner, owner_nxt;
  logic [id_width-1:0] prio_ptr, prio_ptr_nxt;
  logic [id_width-1:0] pick_idx, winner;
  logic                pick_any, win_val, xfer;

  function automatic logic [id_width-1:0] inc_wrap(input logic [id_width-1:0] x);
    return (x == id_width'(num_reqs - 1)) ? '0 : x + 1'b1;
  endfunction

  rr_pick #(
    .num_reqs (num_reqs),
    .id_width (id_width)
  ) u_rr_pick (
    .req      (in_val),
    .prio_ptr (prio_ptr),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  assign winner  = (state == LOCKED) ? owner : pick_idx;
  assign win_val = in_val[winner];
  // Outputs are gated by reset directly so they drop the instant reset asserts.
  assign xfer    = reset & out_rdy & win_val;
  assign out_en  = xfer;
  assign out_msg = in_msg[winner];
  assign locked  = reset & (state == LOCKED);

  always_comb begin
    in_rdy = '0;
    if (xfer) in_rdy[winner] = 1'b1;
  end

  always_comb begin
    grant_id = '0;
    if (reset) grant_id = ((|in_val) || (state == LOCKED)) ? winner : owner;
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    prio_ptr_nxt = prio_ptr;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          owner_nxt = winner;
          if (in_last[winner]) prio_ptr_nxt = inc_wrap(winner);
          else                 state_nxt    = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer && in_last[owner]) begin
          state_nxt    = IDLE;
          prio_ptr_nxt = inc_wrap(owner);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= '0;
      prio_ptr <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      prio_ptr <= prio_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_queue_enq_arbiter.sv
// Directed bench for queue_enq_arbiter: round-robin order, burst lock, backpressure, async reset.
module tb_queue_enq_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic               clk;
  logic               reset;
  logic [NR-1:0]      in_val;
  logic [NR-1:0]      in_last;
  logic [NR-1:0][DW-1:0] in_msg;
  logic [NR-1:0]      in_rdy;
  logic               out_en;
  logic               out_rdy;
  logic [DW-1:0]      out_msg;
  logic [IW-1:0]      grant_id;
  logic               locked;

  int compared   = 0;
  int mismatched = 0;

  queue_enq_arbiter #(.num_reqs(NR), .data_width(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_last  (in_last),
    .in_msg   (in_msg),
    .in_rdy   (in_rdy),
    .out_en   (out_en),
    .out_rdy  (out_rdy),
    .out_msg  (out_msg),
    .grant_id (grant_id),
    .locked   (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] msg_of(input int r, input int beat);
    return 32'hA000_0000 | (DW'(r) << 16) | DW'(beat);
  endfunction

  task automatic set_msgs(input int beat);
    for (int r = 0; r < NR; r++) in_msg[r] = msg_of(r, beat);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    in_val  = '0;
    in_last = '0;
    out_rdy = 1'b1;
    set_msgs(0);

    // Reset state with requests pending
    #2;
    in_val = 4'b1111;
    #1;
    chk("rst_in_rdy", 32'(in_rdy), 32'h0);
    chk("rst_out_en", 32'(out_en), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_grant",  32'(grant_id), 32'h0);
    #9 reset = 1'b1;
    cyc();

    // All valid single-beat: rotating grants 0,1,2,3
    in_last = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      set_msgs(c + 1);
      #1;
      chk("rr_grant",  32'(grant_id), 32'(c));
      chk("rr_in_rdy", 32'(in_rdy), 32'(1 << c));
      chk("rr_out_en", 32'(out_en), 32'h1);
      chk("rr_msg",    out_msg, msg_of(c, c + 1));
      cyc();
    end

    // Single beat from 1 moves pointer to 2
    in_val = 4'b0010; in_last = 4'b0010;
    #1;
    chk("ptr_setup_grant", 32'(grant_id), 32'h1);
    cyc();

    // 3-beat burst from 2 while 0 and 3 compete
    in_val = 4'b1101; in_last = 4'b1001; set_msgs(11);
    #1;
    chk("b1_grant",  32'(grant_id), 32'h2);
    chk("b1_locked", 32'(locked), 32'h0);
    chk("b1_in_rdy", 32'(in_rdy), 32'h4);
    chk("b1_msg",    out_msg, msg_of(2, 11));
    cyc();
    set_msgs(12);
    #1;
    chk("b2_locked", 32'(locked), 32'h1);
    chk("b2_in_rdy", 32'(in_rdy), 32'h4);
    chk("b2_msg",    out_msg, msg_of(2, 12));
    cyc();
    in_last = 4'b1101; set_msgs(13);
    #1;
    chk("b3_locked", 32'(locked), 32'h1);
    chk("b3_grant",  32'(grant_id), 32'h2);
    chk("b3_msg",    out_msg, msg_of(2, 13));
    cyc();

    // After burst: next grant 3, then pointer wraps to 0
    in_val = 4'b1001; in_last = 4'b1001;
    #1;
    chk("post_burst_grant", 32'(grant_id), 32'h3);
    chk("post_burst_locked", 32'(locked), 32'h0);
    cyc();
    #1;
    chk("wrap_grant",  32'(grant_id), 32'h0);
    chk("wrap_in_rdy", 32'(in_rdy), 32'h1);
    cyc();

    // Lock owner 1 (pointer now 1), then backpressure for 5 cycles
    in_val = 4'b0010; in_last = 4'b0000;
    #1;
    chk("lock1_grant", 32'(grant_id), 32'h1);
    cyc();
    out_rdy = 1'b0; in_val = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_in_rdy", 32'(in_rdy), 32'h0);
      chk("bp_out_en", 32'(out_en), 32'h0);
      chk("bp_locked", 32'(locked), 32'h1);
      chk("bp_grant",  32'(grant_id), 32'h1);
      cyc();
    end
    out_rdy = 1'b1; in_last = 4'b1111; set_msgs(21);
    #1;
    chk("bp_rel_in_rdy", 32'(in_rdy), 32'h2);
    chk("bp_rel_msg",    out_msg, msg_of(1, 21));
    cyc();
    #1;
    chk("bp_unlock", 32'(locked), 32'h0);

    // Idle with no requests: grant_id shows last owner, nothing moves
    in_val = 4'b0000;
    #1;
    chk("idle_out_en", 32'(out_en), 32'h0);
    chk("idle_grant",  32'(grant_id), 32'h1);
    cyc();
    // Pointer is 2: search 2,3,0 -> 0
    in_val = 4'b0001; in_last = 4'b0001;
    #1;
    chk("idle_ptr_kept", 32'(grant_id), 32'h0);
    cyc();

    // Burst from 2 (pointer 1), then async reset mid-burst
    in_val = 4'b0100; in_last = 4'b0000;
    #1;
    chk("rb_grant", 32'(grant_id), 32'h2);
    cyc();
    #1;
    chk("rb_locked", 32'(locked), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("rb_rst_locked", 32'(locked), 32'h0);
    chk("rb_rst_in_rdy", 32'(in_rdy), 32'h0);
    chk("rb_rst_grant",  32'(grant_id), 32'h0);
    in_val = 4'b0110; in_last = 4'b0000;
    #1 reset = 1'b1;
    #1;
    chk("rb_after_grant",  32'(grant_id), 32'h1);
    chk("rb_after_in_rdy", 32'(in_rdy), 32'h2);
    chk("rb_after_locked", 32'(locked), 32'h0);
    cyc();
    #1;
    chk("rb_relock_in_rdy", 32'(in_rdy), 32'h2);
    chk("rb_relock_locked", 32'(locked), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/queue_enq_arbiter.md
QUEUE_ENQ_ARBITER -- requirements
Module: queue_enq_arbiter

Interface
REQ-001 Parameter num_reqs, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter data_width, default 32: message width in bits.
REQ-003 Parameter id_width, default $clog2(num_reqs): grant-index width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_val  input  num_reqs  per-requester message-valid.
REQ-007 in_last  input  num_reqs  per-requester end-of-burst marker, qualified by in_val.
REQ-008 in_msg  input  num_reqs x data_width  per-requester message.
REQ-009 in_rdy  output  num_reqs  per-requester accept; a transfer occurs when in_val[i] & in_rdy[i].
REQ-010 out_en  output  1  enqueue strobe to the shared queue.
REQ-011 out_rdy  input  1  shared-queue enq_rdy.
REQ-012 out_msg  output  data_width  enqueue message to the shared queue.
REQ-013 grant_id  output  id_width  index of the current or last granted requester.
REQ-014 locked  output  1  high while a burst owns the queue.

Function
REQ-015 Two states SHALL exist: IDLE (no owner) and LOCKED (owner holds the queue until its last beat).
REQ-016 In IDLE, the winner SHALL be the first requester with in_val high, searching from prio_ptr upward with wrap to 0.
REQ-017 In LOCKED, the winner SHALL be owner only; other requesters' in_val SHALL be ignored.
REQ-018 in_rdy[i] SHALL equal out_rdy & (i == winner) & in_val[winner]; at most one in_rdy bit high per cycle.
REQ-019 out_en SHALL equal out_rdy & in_val[winner], combinationally; out_en never high while out_rdy is low.
REQ-020 out_msg SHALL equal in_msg[winner] whenever out_en is high; out_msg is don't-care otherwise.
REQ-021 Zero-cycle latency: an accepted beat SHALL reach the queue enq port in the same cycle.
REQ-022 IDLE transfer with in_last=0: next state LOCKED, owner <= winner; prio_ptr unchanged.
REQ-023 IDLE transfer with in_last=1 (single-beat burst): stay IDLE, prio_ptr <= winner+1 with wrap at num_reqs-1 to 0.
REQ-024 LOCKED transfer with in_last=1: next state IDLE, prio_ptr <= owner+1 with wrap.
REQ-025 LOCKED, owner in_val low or out_rdy low: hold state, owner and prio_ptr; no transfer.
REQ-026 No requests in IDLE: no transfer, state and prio_ptr unchanged.
REQ-027 Full queue (out_rdy=0): all in_rdy low; no state change.
REQ-028 grant_id SHALL show the winner when any in_val is high or LOCKED, otherwise the last owner.
REQ-029 locked SHALL be high exactly in state LOCKED.

Reset
REQ-030 Assertion of reset SHALL immediately force state IDLE, prio_ptr 0, owner 0, independent of clk.
REQ-031 During reset: in_rdy all 0, out_en 0, locked 0, grant_id 0.
REQ-032 Reset mid-burst SHALL abandon the burst; the first cycle after deassertion arbitrates from requester 0.

Structure
REQ-033 A shared package queue_arb_pkg SHALL hold the state enum (IDLE, LOCKED) and the default num_reqs and data_width constants.
REQ-034 One sub-module rr_pick (combinational round-robin pick from request vector and prio_ptr, returning index and any-valid) SHALL be used; all registers SHALL live in queue_enq_arbiter.

Verification
REQ-035 After reset, num_reqs=4, in_val=4'b1111, all in_last=1, out_rdy=1 for 4 cycles -> grant_id sequence 0,1,2,3; one out_en per cycle.
REQ-036 Requester 2 sends a 3-beat burst (last on beat 3) while requesters 0 and 3 are valid -> out_msg carries only requester 2 beats 1..3, locked high for beats 2..3; next grant is 3.
REQ-037 LOCKED owner 1 with out_rdy low for 5 cycles -> in_rdy=0, out_en=0, state held; out_rdy high -> beat accepted from requester 1 only.
REQ-038 prio_ptr=3, single-beat grant to 3 -> prio_ptr wraps to 0; in_val=4'b1001 -> next grant 0.
REQ-039 Reset asserted between clock edges mid-burst -> locked and in_rdy drop at once; after release with in_val=4'b0110 -> grant 1.
REQ-040 Queue model of depth 2 behind the arbiter, random in_val/in_last, 1000 cycles -> no beat lost or duplicated, bursts never interleaved, out_en never high while out_rdy is low.
